// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
//   XLEN / INST_W  : address and instruction widths
//   NOP_INST       : filler word carried by a misaligned-target entry
//   fetch_state_e  : RUN (normal fetch) / HALT (misaligned target pending)
//   fetch_slot_t   : one slot-ring entry {pc, inst, exc, filled}
package fetch_pkg;

  localparam int XLEN   = 64;
  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              exc;
    logic              filled;
  } fetch_slot_t;

endpackage

// File: rtl/fetch_slot_ring.sv
// Slot ring holding allocated fetches in program order.
// Three wrapping pointers (one extra bit to tell full from empty):
//   tail : next slot to allocate (written with the request PC on issue)
//   fill : next slot to receive an instruction word from memory
//   head : oldest slot, presented to decode
// Ports:
//   clock, reset         clock / asynchronous active-low reset
//   clear, clear_prefill empty the ring; optionally seed slot 0 with a
//   prefill_pc           ready-made misaligned-target entry
//   alloc_en, alloc_pc   allocate at tail
//   fill_en, fill_inst   write instruction into the fill slot
//   deq_en               retire the head slot
//   head_*               contents of the head slot and whether it is filled
//   alloc_cnt            allocated slots (queued + in flight)
//   unfilled_cnt         allocated slots still waiting on memory
module fetch_slot_ring
  import fetch_pkg::*;
#(
  parameter int QDEPTH = 4,
  parameter int PW     = $clog2(QDEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              clear_prefill,
  input  logic [XLEN-1:0]   prefill_pc,
  input  logic              alloc_en,
  input  logic [XLEN-1:0]   alloc_pc,
  input  logic              fill_en,
  input  logic [INST_W-1:0] fill_inst,
  input  logic              deq_en,
  output logic              head_filled,
  output logic [XLEN-1:0]   head_pc,
  output logic [INST_W-1:0] head_inst,
  output logic              head_exc,
  output logic [PW-1:0]     alloc_cnt,
  output logic [PW-1:0]     unfilled_cnt
);

  localparam int IW = $clog2(QDEPTH);

  fetch_slot_t       slots [QDEPTH];
  logic [PW-1:0]     head_ptr;
  logic [PW-1:0]     fill_ptr;
  logic [PW-1:0]     tail_ptr;
  fetch_slot_t       head_slot;

  assign alloc_cnt    = tail_ptr - head_ptr;
  assign unfilled_cnt = tail_ptr - fill_ptr;
  assign head_slot    = slots[head_ptr[IW-1:0]];
  // A stale filled flag in an empty ring must not look like a valid entry.
  assign head_filled  = (alloc_cnt != '0) && head_slot.filled;
  assign head_pc      = head_slot.pc;
  assign head_inst    = head_slot.inst;
  assign head_exc     = head_slot.exc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      head_ptr <= '0;
      fill_ptr <= '0;
      tail_ptr <= '0;
      for (int i = 0; i < QDEPTH; i++) slots[i] <= '0;
    end else if (clear) begin
      for (int i = 0; i < QDEPTH; i++) slots[i].filled <= 1'b0;
      head_ptr <= '0;
      if (clear_prefill) begin
        // Entry is complete at birth: allocated and filled, never sent to memory.
        slots[0] <= '{pc: prefill_pc, inst: NOP_INST, exc: 1'b1, filled: 1'b1};
        fill_ptr <= PW'(1);
        tail_ptr <= PW'(1);
      end else begin
        fill_ptr <= '0;
        tail_ptr <= '0;
      end
    end else begin
      if (alloc_en) begin
        slots[tail_ptr[IW-1:0]] <= '{pc: alloc_pc, inst: '0, exc: 1'b0, filled: 1'b0};
        tail_ptr <= tail_ptr + PW'(1);
      end
      if (fill_en) begin
        slots[fill_ptr[IW-1:0]].inst   <= fill_inst;
        slots[fill_ptr[IW-1:0]].filled <= 1'b1;
        fill_ptr <= fill_ptr + PW'(1);
      end
      if (deq_en) head_ptr <= head_ptr + PW'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end. Owns the PC, issues in-order 32-bit imem
// reads, buffers returned words in a slot ring and hands {pc, inst, exc}
// to decode. A redirect squashes everything queued or in flight; responses
// still owed for squashed requests are counted in drop_cnt and discarded.
// A misaligned redirect target produces a single exception entry and parks
// the unit in HALT until an aligned redirect arrives.
// Ports:
//   clock, reset                      clock / asynchronous active-low reset
//   io_redir_valid, io_redir_target   redirect request and new PC
//   io_imem_req_*                     fetch request (addr = current PC)
//   io_imem_resp_*                    in-order instruction responses
//   io_out_*                          decode entry {pc, inst, exc}
//   io_perf_fetch_cnt/flush_cnt       delivery / redirect counters
// Optional feature: define FETCH_PERF_EN to build the performance counters;
// otherwise both counter ports are tied to zero.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          QDEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_redir_valid,
  input  logic [63:0] io_redir_target,
  output logic        io_imem_req_valid,
  input  logic        io_imem_req_ready,
  output logic [63:0] io_imem_req_addr,
  input  logic        io_imem_resp_valid,
  input  logic [31:0] io_imem_resp_data,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [63:0] io_out_pc,
  output logic [31:0] io_out_inst,
  output logic        io_out_exc,
  output logic [63:0] io_perf_fetch_cnt,
  output logic [31:0] io_perf_flush_cnt
);

  localparam int PW = $clog2(QDEPTH) + 1;

  fetch_state_e  state;
  logic [63:0]   pc;
  logic [PW-1:0] drop_cnt;
  logic [PW-1:0] alloc_cnt;
  logic [PW-1:0] unfilled_cnt;
  logic [PW-1:0] occupancy;
  logic [PW-1:0] pending;
  logic [PW-1:0] redir_drop;
  logic          head_filled;
  logic          misaligned;
  logic          req_fire;
  logic          resp_drop;
  logic          resp_fill;
  logic          out_fire;

  // Squashed-but-owed responses still reserve capacity, so a redirect cannot
  // let the unit run further ahead of memory than the ring depth.
  assign occupancy  = alloc_cnt + drop_cnt;
  assign misaligned = |io_redir_target[1:0];

  assign io_imem_req_valid = reset && (state == RUN) && !io_redir_valid &&
                             (occupancy < PW'(QDEPTH));
  assign io_imem_req_addr  = pc;
  assign req_fire          = io_imem_req_valid && io_imem_req_ready;

  assign resp_drop = io_imem_resp_valid && (drop_cnt != '0);
  assign resp_fill = io_imem_resp_valid && (drop_cnt == '0) &&
                     (unfilled_cnt != '0) && !io_redir_valid;

  assign io_out_valid = head_filled && !io_redir_valid;
  assign out_fire     = io_out_valid && io_out_ready;

  // On redirect every unfilled slot becomes a response to discard; a response
  // arriving in the redirect cycle itself pays one of those off immediately.
  assign pending    = drop_cnt + unfilled_cnt;
  assign redir_drop = (io_imem_resp_valid && (pending != '0)) ? pending - PW'(1) : pending;

  fetch_slot_ring #(
    .QDEPTH (QDEPTH),
    .PW     (PW)
  ) u_ring (
    .clock         (clock),
    .reset         (reset),
    .clear         (io_redir_valid),
    .clear_prefill (io_redir_valid && misaligned),
    .prefill_pc    (io_redir_target),
    .alloc_en      (req_fire),
    .alloc_pc      (pc),
    .fill_en       (resp_fill),
    .fill_inst     (io_imem_resp_data),
    .deq_en        (out_fire),
    .head_filled   (head_filled),
    .head_pc       (io_out_pc),
    .head_inst     (io_out_inst),
    .head_exc      (io_out_exc),
    .alloc_cnt     (alloc_cnt),
    .unfilled_cnt  (unfilled_cnt)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      drop_cnt <= '0;
    end else if (io_redir_valid) begin
      pc       <= io_redir_target;
      drop_cnt <= redir_drop;
      state    <= misaligned ? HALT : RUN;
    end else begin
      if (req_fire)  pc       <= pc + 64'd4;
      if (resp_drop) drop_cnt <= drop_cnt - PW'(1);
    end
  end

`ifdef FETCH_PERF_EN
  logic [63:0] fetch_cnt;
  logic [31:0] flush_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fetch_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (out_fire)       fetch_cnt <= fetch_cnt + 64'd1;
      if (io_redir_valid) flush_cnt <= flush_cnt + 32'd1;
    end
  end

  assign io_perf_fetch_cnt = fetch_cnt;
  assign io_perf_flush_cnt = flush_cnt;
`else
  assign io_perf_fetch_cnt = '0;
  assign io_perf_flush_cnt = '0;
`endif

`ifndef SYNTHESIS
  // Every response must belong to a request that is still owed one.
  resp_has_owner: assert property (@(posedge clock) disable iff (!reset)
    io_imem_resp_valid |-> ((drop_cnt != '0) || (unfilled_cnt != '0)));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam int          QDEPTH   = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_redir_valid;
  logic [63:0] io_redir_target;
  logic        io_imem_req_valid;
  logic        io_imem_req_ready;
  logic [63:0] io_imem_req_addr;
  logic        io_imem_resp_valid;
  logic [31:0] io_imem_resp_data;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [63:0] io_out_pc;
  logic [31:0] io_out_inst;
  logic        io_out_exc;
  logic [63:0] io_perf_fetch_cnt;
  logic [31:0] io_perf_flush_cnt;

  always #5 clock = ~clock;

  fetch_unit #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
    .clock              (clock),
    .reset              (reset),
    .io_redir_valid     (io_redir_valid),
    .io_redir_target    (io_redir_target),
    .io_imem_req_valid  (io_imem_req_valid),
    .io_imem_req_ready  (io_imem_req_ready),
    .io_imem_req_addr   (io_imem_req_addr),
    .io_imem_resp_valid (io_imem_resp_valid),
    .io_imem_resp_data  (io_imem_resp_data),
    .io_out_valid       (io_out_valid),
    .io_out_ready       (io_out_ready),
    .io_out_pc          (io_out_pc),
    .io_out_inst        (io_out_inst),
    .io_out_exc         (io_out_exc),
    .io_perf_fetch_cnt  (io_perf_fetch_cnt),
    .io_perf_flush_cnt  (io_perf_flush_cnt)
  );

  // Memory transactions the bench still owes a response for.
  typedef struct {
    logic [63:0] addr;
    int          epoch;
    int          ready_cyc;
  } mreq_t;

  mreq_t       memq[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  // Reference model: the decode stream since the last redirect is
  // target, target+4, ... with inst = inst_of(pc); a misaligned target yields
  // exactly one {target, 0x13, exc} entry and then nothing.
  int          epoch = 0;
  int          buffered = 0;
  logic        halted = 1'b0;
  logic        exc_pending = 1'b0;
  logic [63:0] exc_pc = '0;
  logic [63:0] exp_req = RESET_PC;
  logic [63:0] exp_out = RESET_PC;
  logic [63:0] n_deliv = '0;
  logic [31:0] n_redir = '0;
  int          req_ready_pct = 100;
  int          out_ready_pct = 100;
  int          resp_pct = 100;
  int          max_delay = 1;

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic check_perf(input string tag);
`ifdef FETCH_PERF_EN
    check({tag, "_fetch_cnt"}, io_perf_fetch_cnt, n_deliv);
    check({tag, "_flush_cnt"}, 64'(io_perf_flush_cnt), 64'(n_redir));
`else
    check({tag, "_fetch_cnt"}, io_perf_fetch_cnt, 64'd0);
    check({tag, "_flush_cnt"}, 64'(io_perf_flush_cnt), 64'd0);
`endif
  endtask

  task automatic model_reset();
    memq.delete();
    epoch++;
    buffered    = 0;
    halted      = 1'b0;
    exc_pending = 1'b0;
    exp_req     = RESET_PC;
    exp_out     = RESET_PC;
    n_deliv     = '0;
    n_redir     = '0;
  endtask

  // One clock cycle: drive at posedge+1, check and update the model at negedge.
  task automatic step(input logic rv, input logic [63:0] rt);
    logic  resp, exp_rv, exp_ov, rfire, ofire;
    mreq_t m;
    io_redir_valid    = rv;
    io_redir_target   = rt;
    io_imem_req_ready = ($urandom_range(99) < req_ready_pct);
    io_out_ready      = ($urandom_range(99) < out_ready_pct);
    resp = (memq.size() > 0) && (memq[0].ready_cyc <= cyc) && ($urandom_range(99) < resp_pct);
    io_imem_resp_valid = resp;
    io_imem_resp_data  = resp ? inst_of(memq[0].addr) : $urandom;
    @(negedge clock);
    exp_rv = !halted && !rv && ((memq.size() + buffered) < QDEPTH);
    exp_ov = !rv && (buffered > 0);
    check("req_valid", 64'(io_imem_req_valid), 64'(exp_rv));
    check("req_addr", io_imem_req_addr, exp_req);
    check("out_valid", 64'(io_out_valid), 64'(exp_ov));
    rfire = exp_rv && io_imem_req_ready;
    ofire = exp_ov && io_out_ready;
    if (ofire) begin
      if (exc_pending) begin
        check("exc_pc", io_out_pc, exc_pc);
        check("exc_inst", 64'(io_out_inst), 64'h13);
        check("exc_flag", 64'(io_out_exc), 64'd1);
        exc_pending = 1'b0;
      end else begin
        check("out_pc", io_out_pc, exp_out);
        check("out_inst", 64'(io_out_inst), 64'(inst_of(exp_out)));
        check("out_exc", 64'(io_out_exc), 64'd0);
        exp_out += 64'd4;
      end
      buffered--;
      n_deliv++;
    end
    if (resp) begin
      m = memq.pop_front();
      if (!rv && m.epoch == epoch) buffered++;
    end
    if (rfire) begin
      m.addr      = exp_req;
      m.epoch     = epoch;
      m.ready_cyc = cyc + int'($urandom_range(max_delay, 1));
      memq.push_back(m);
      exp_req += 64'd4;
    end
    if (rv) begin
      epoch++;
      n_redir++;
      exp_req = rt;
      exp_out = rt;
      if (rt[1:0] != 2'b00) begin
        halted = 1'b1; exc_pending = 1'b1; exc_pc = rt; buffered = 1;
      end else begin
        halted = 1'b0; exc_pending = 1'b0; buffered = 0;
      end
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    io_redir_valid     = 1'b0;
    io_redir_target    = '0;
    io_imem_req_ready  = 1'b0;
    io_imem_resp_valid = 1'b0;
    io_imem_resp_data  = '0;
    io_out_ready       = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_valid"}, 64'(io_imem_req_valid), 64'd0);
    check({tag, "_req_addr"}, io_imem_req_addr, RESET_PC);
    check({tag, "_out_valid"}, 64'(io_out_valid), 64'd0);
    check({tag, "_perf_fetch"}, io_perf_fetch_cnt, 64'd0);
    check({tag, "_perf_flush"}, 64'(io_perf_flush_cnt), 64'd0);
  endtask

  function automatic logic [63:0] rand_target();
    logic [63:0] t;
    t = {32'h0, 32'h8000_0000 | ($urandom & 32'h0000_FFFC)};
    if ($urandom_range(99) < 20) t[1:0] = 2'($urandom_range(3, 1));
    return t;
  endfunction

  task automatic random_run(input int n);
    repeat (n) begin
      if ($urandom_range(99) < 6) step(1'b1, rand_target());
      else step(1'b0, '0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    @(negedge clock);
    check_reset_state("rst");
    check("rst_out_pc", io_out_pc, 64'd0);
    check("rst_out_inst", 64'(io_out_inst), 64'd0);
    check("rst_out_exc", 64'(io_out_exc), 64'd0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Streaming with single-cycle memory and an always-ready decode.
    repeat (20) step(1'b0, '0);
    // Decode stalled: issue must stop once the ring is full.
    out_ready_pct = 0;
    repeat (10) step(1'b0, '0);
    out_ready_pct = 100;
    repeat (4) step(1'b0, '0);
    // Redirect with fetches in flight.
    max_delay = 3;
    repeat (6) step(1'b0, '0);
    step(1'b1, 64'h8000_1000);
    repeat (15) step(1'b0, '0);
    // Misaligned target, then a second misaligned one while halted.
    step(1'b1, 64'h8000_0002);
    repeat (8) step(1'b0, '0);
    step(1'b1, 64'h8000_0100);
    repeat (10) step(1'b0, '0);
    step(1'b1, 64'h8000_0206);
    repeat (3) step(1'b0, '0);
    step(1'b1, 64'h8000_020A);
    repeat (4) step(1'b0, '0);
    step(1'b1, 64'h8000_0300);
    repeat (8) step(1'b0, '0);
    // Back-to-back redirects and 64-bit PC wrap.
    step(1'b1, 64'h8000_0400);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    repeat (12) step(1'b0, '0);
    check_perf("directed");

    req_ready_pct = 70; out_ready_pct = 60; resp_pct = 70; max_delay = 4;
    random_run(1500);
    check_perf("random");

    // Reset in the middle of traffic.
    idle_inputs();
    reset = 1'b0;
    @(negedge clock);
    check_reset_state("midrst");
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b1;
    random_run(300);
    check_perf("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
